// File: rtl/iq_pkg.sv
// Shared definitions for the issue queue.
//  - ptr_width / lane_cnt_width: width derivations that the queue and its
//    interface reuse, so pointer and count widths always agree.
//  - PTR_W / CNT_W: widths for the default 16-entry, 2-wide configuration.
//  - iq_lane_cnt_t: lane-count type (deq_avail / deq_cnt) for the default
//    configuration.
//  - popcount: number of set bits in a valid mask (up to 64 lanes).
package iq_pkg;

  localparam int IQ_DEPTH  = 16;
  localparam int IQ_ENQ_W  = 2;
  localparam int IQ_DEQ_W  = 2;
  localparam int IQ_DATA_W = 128;

  // Pointers carry one extra wrap bit above the index bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lane_cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  localparam int PTR_W = ptr_width(IQ_DEPTH);
  // Occupancy spans 0..DEPTH, so it needs the same width as a pointer.
  localparam int CNT_W = PTR_W;

  typedef logic [lane_cnt_width(IQ_DEQ_W)-1:0] iq_lane_cnt_t;

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/issue_queue_nw_if.sv
// Decode/issue side bundle of the issue queue.
//  master : decode + issue stages (drive flush, enqueue lanes, deq_cnt)
//  slave  : the queue (drives ready/status and the fall-through read lanes)
//  flush        discard all entries
//  enq_valid    per-lane valid, holes allowed
//  enq_data     lane i at [i*DATA_W +: DATA_W]
//  enq_ready    free slots >= ENQ_W
//  deq_data     lane 0 = oldest entry
//  deq_avail    min(count, DEQ_W)
//  deq_cnt      entries consumed this cycle
//  count        occupancy
//  empty/full/almost_full  status
interface issue_queue_nw_if
  import iq_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int ENQ_W  = IQ_ENQ_W,
  parameter int DEQ_W  = IQ_DEQ_W,
  parameter int DATA_W = IQ_DATA_W
);

  logic                                flush;
  logic [ENQ_W-1:0]                    enq_valid;
  logic [ENQ_W*DATA_W-1:0]             enq_data;
  logic                                enq_ready;
  logic [DEQ_W*DATA_W-1:0]             deq_data;
  logic [lane_cnt_width(DEQ_W)-1:0]    deq_avail;
  logic [lane_cnt_width(DEQ_W)-1:0]    deq_cnt;
  logic [ptr_width(DEPTH)-1:0]         count;
  logic                                empty;
  logic                                full;
  logic                                almost_full;

  modport master (
    output flush, enq_valid, enq_data, deq_cnt,
    input  enq_ready, deq_data, deq_avail, count, empty, full, almost_full
  );

  modport slave (
    input  flush, enq_valid, enq_data, deq_cnt,
    output enq_ready, deq_data, deq_avail, count, empty, full, almost_full
  );

endinterface

// File: rtl/iq_compact.sv
// Combinational enqueue-lane compactor.
//  valid    : per-lane valid mask (holes allowed)
//  data_in  : ENQ_W lanes, lane i at [i*DATA_W +: DATA_W]
//  data_out : valid lanes packed towards slot 0 in lane order; unused slots 0
//  n_enq    : number of valid lanes
module iq_compact
  import iq_pkg::*;
#(
  parameter int ENQ_W  = 2,
  parameter int DATA_W = 128
) (
  input  logic [ENQ_W-1:0]                 valid,
  input  logic [ENQ_W*DATA_W-1:0]          data_in,
  output logic [ENQ_W*DATA_W-1:0]          data_out,
  output logic [lane_cnt_width(ENQ_W)-1:0] n_enq
);

  localparam int ECW = lane_cnt_width(ENQ_W);

  int slot;

  always_comb begin
    data_out = '0;
    slot     = 0;
    for (int i = 0; i < ENQ_W; i++) begin
      if (valid[i]) begin
        data_out[slot*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
        slot = slot + 1;
      end
    end
  end

  assign n_enq = ECW'(popcount(64'(valid)));

endmodule

// File: rtl/issue_queue_nw.sv
// N-in/M-out circular instruction queue between decode and issue.
//  clk    : clock, rising edge
//  reset  : asynchronous, active-high; clears pointers only (storage keeps data)
//  q      : issue_queue_nw_if.slave bundle (enqueue lanes, fall-through
//           dequeue lanes, consumed count, flush, status)
// Up to ENQ_W entries are written per cycle (holes compacted), up to DEQ_W
// oldest entries are presented combinationally from registered state, and
// issue reports via deq_cnt how many it took. Flush beats enqueue/dequeue.
module issue_queue_nw
  import iq_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int ENQ_W         = 2,
  parameter int DEQ_W         = 2,
  parameter int DATA_W        = 128,
  parameter int AFULL_TH      = DEPTH - 4,
  parameter bit DEQ_CNT_CHECK = 1'b1
) (
  input logic               clk,
  input logic               reset,
  issue_queue_nw_if.slave   q
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int QPTR_W = ptr_width(DEPTH);
  localparam int ECW    = lane_cnt_width(ENQ_W);
  localparam int DCW    = lane_cnt_width(DEQ_W);

  logic [QPTR_W-1:0]       head;
  logic [QPTR_W-1:0]       tail;
  logic [QPTR_W-1:0]       cnt;
  logic [QPTR_W-1:0]       free_slots;
  logic                    enq_ready_w;
  logic                    do_enq;
  logic [DCW-1:0]          deq_avail_w;
  logic [DCW-1:0]          n_deq;
  logic [ECW-1:0]          n_enq;
  logic [ENQ_W*DATA_W-1:0] packed_data;
  logic [ADDR_W-1:0]       wr_idx [ENQ_W];
  logic [ADDR_W-1:0]       rd_idx [DEQ_W];
  logic [DEQ_W*DATA_W-1:0] deq_data_w;
  logic [DATA_W-1:0]       mem [DEPTH];

  iq_compact #(
    .ENQ_W  (ENQ_W),
    .DATA_W (DATA_W)
  ) u_compact (
    .valid    (q.enq_valid),
    .data_in  (q.enq_data),
    .data_out (packed_data),
    .n_enq    (n_enq)
  );

  // Occupancy falls out of the wrap-bit pointers, modulo 2^QPTR_W.
  assign cnt        = tail - head;
  assign free_slots = QPTR_W'(DEPTH) - cnt;

  // Ready looks only at registered occupancy, never at this cycle's deq_cnt,
  // so fetch stall does not sit behind the issue-select path.
  assign enq_ready_w = (free_slots >= QPTR_W'(ENQ_W));
  assign do_enq      = enq_ready_w && !q.flush;

  assign deq_avail_w = (cnt < QPTR_W'(DEQ_W)) ? DCW'(cnt) : DCW'(DEQ_W);
  assign n_deq       = (q.deq_cnt > deq_avail_w) ? deq_avail_w : q.deq_cnt;

  always_comb begin
    for (int s = 0; s < ENQ_W; s++) wr_idx[s] = ADDR_W'(tail + QPTR_W'(s));
    for (int j = 0; j < DEQ_W; j++) rd_idx[j] = ADDR_W'(head + QPTR_W'(j));
  end

  // Pointer state: the only thing reset and flush touch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_enq) tail <= tail + QPTR_W'(n_enq);
      head <= head + QPTR_W'(n_deq);
    end
  end

  // Storage: compacted slot s lands at tail+s.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      for (int s = 0; s < ENQ_W; s++) begin
        if (ECW'(s) < n_enq) mem[wr_idx[s]] <= packed_data[s*DATA_W +: DATA_W];
      end
    end
  end

  // Fall-through read lanes; lanes past the occupancy read as zero.
  always_comb begin
    deq_data_w = '0;
    for (int j = 0; j < DEQ_W; j++) begin
      if (DCW'(j) < deq_avail_w) deq_data_w[j*DATA_W +: DATA_W] = mem[rd_idx[j]];
    end
  end

  assign q.deq_data    = deq_data_w;
  assign q.deq_avail   = deq_avail_w;
  assign q.count       = cnt;
  assign q.enq_ready   = enq_ready_w;
  assign q.full        = !enq_ready_w;
  assign q.empty       = (cnt == '0);
  assign q.almost_full = (cnt >= QPTR_W'(AFULL_TH));

`ifndef SYNTHESIS
  // Over-consumption is clamped in hardware but flags an issue-stage bug.
  always_ff @(posedge clk) begin
    if (DEQ_CNT_CHECK && !reset && !q.flush && cnt != '0 && q.deq_cnt > deq_avail_w)
      $error("issue_queue_nw: deq_cnt %0d exceeds deq_avail %0d", q.deq_cnt, deq_avail_w);
  end
`endif

endmodule
